// File: rtl/alu_pipe_pkg.sv
// ============================================================================
// Module   : alu_pipe_pkg
// Purpose  : Shared opcode encoding and flag bundle for the pipelined ALU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pipe_pkg;

  localparam int unsigned OP_W = 4;

  // Opcode map; codes 11..15 are reserved and yield a zero result
  typedef enum logic [OP_W-1:0] {
    OP_AND    = 4'd0,
    OP_OR     = 4'd1,
    OP_XOR    = 4'd2,
    OP_NOR    = 4'd3,
    OP_ADD    = 4'd4,
    OP_SUB    = 4'd5,
    OP_SLT    = 4'd6,
    OP_SLL    = 4'd7,
    OP_SRL    = 4'd8,
    OP_SRA    = 4'd9,
    OP_PASS_B = 4'd10
  } alu_op_e;

  // Flags travel down the pipe next to the result as one packed word
  typedef struct packed {
    logic zero;
    logic ovf;
    logic neg;
    logic carry;
  } alu_flags_t;

endpackage

`default_nettype wire

// File: rtl/alu_pipe_if.sv
// ============================================================================
// Module   : alu_pipe_if
// Purpose  : Issue-side and writeback-side valid/ready bundle of alu_pipe.
//            The sticky overflow pair exists only with ALU_PIPE_STICKY_OVF_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_pipe_if #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
);

  // Operand bundle handshake
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  A_in;
  logic [WIDTH-1:0]  B_in;
  logic [CTRL_W-1:0] Alu_Cntrl_in;
  logic              Cin_in;

  // Result handshake
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  OUT;
  logic              Zero;
  logic              oVerflow;
  logic              Negative;
  logic              Carry;

`ifdef ALU_PIPE_STICKY_OVF_EN
  logic              sticky_ovf;
  logic              sticky_clr;
`endif

  // Issue logic / writeback logic side
  modport master (
    output in_valid, A_in, B_in, Alu_Cntrl_in, Cin_in, out_ready,
    input  in_ready, out_valid, OUT, Zero, oVerflow, Negative, Carry
`ifdef ALU_PIPE_STICKY_OVF_EN
    , output sticky_clr
    , input  sticky_ovf
`endif
  );

  // The ALU pipeline itself
  modport slave (
    input  in_valid, A_in, B_in, Alu_Cntrl_in, Cin_in, out_ready,
    output in_ready, out_valid, OUT, Zero, oVerflow, Negative, Carry
`ifdef ALU_PIPE_STICKY_OVF_EN
    , input  sticky_clr
    , output sticky_ovf
`endif
  );

endinterface

`default_nettype wire

// File: rtl/alu_core.sv
// ============================================================================
// Module   : alu_core
// Purpose  : Combinational ALU: logic ops, add/sub with carry and signed
//            overflow, signed compare, shifts and pass-through of B.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_core
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [CTRL_W-1:0] op,
  input  logic              cin,
  output logic [WIDTH-1:0]  result,
  output alu_flags_t        flags
);

  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0]   shamt;
  logic             is_add;
  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  logic [WIDTH:0]   sum;
  logic             arith_ovf;

  assign shamt = b[SHW-1:0];

  // One shared adder; SUB is A + ~B + 1 so Carry=1 means no borrow
  always_comb begin
    is_add    = (op == CTRL_W'(OP_ADD));
    is_sub    = (op == CTRL_W'(OP_SUB));
    b_eff     = is_sub ? ~b : b;
    c_eff     = is_sub ? 1'b1 : cin;
    sum       = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, c_eff};
    arith_ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  end

  // Result select; reserved opcodes fall through to zero
  always_comb begin
    result = '0;
    case (op)
      CTRL_W'(OP_AND):    result = a & b;
      CTRL_W'(OP_OR):     result = a | b;
      CTRL_W'(OP_XOR):    result = a ^ b;
      CTRL_W'(OP_NOR):    result = ~(a | b);
      CTRL_W'(OP_ADD):    result = sum[WIDTH-1:0];
      CTRL_W'(OP_SUB):    result = sum[WIDTH-1:0];
      CTRL_W'(OP_SLT):    result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      CTRL_W'(OP_SLL):    result = a << shamt;
      CTRL_W'(OP_SRL):    result = a >> shamt;
      CTRL_W'(OP_SRA):    result = $signed(a) >>> shamt;
      CTRL_W'(OP_PASS_B): result = b;
      default:            result = '0;
    endcase
  end

  // Carry and overflow only mean something for the adder ops
  always_comb begin
    flags       = '0;
    flags.zero  = (result == '0);
    flags.neg   = result[WIDTH-1];
    flags.carry = (is_add || is_sub) ? sum[WIDTH] : 1'b0;
    flags.ovf   = (is_add || is_sub) ? arith_ovf  : 1'b0;
  end

endmodule

`default_nettype wire

// File: rtl/alu_pipe.sv
// ============================================================================
// Module   : alu_pipe
// Purpose  : Valid/ready pipelined ALU. Stage 1 holds the operand bundle,
//            the ALU evaluates stage 1, stages 2..LATENCY carry result and
//            flags. Lossless backpressure, one op per cycle, capacity LATENCY.
//            Optional macro ALU_PIPE_STICKY_OVF_EN adds a sticky overflow bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH   = 32,  // >= 4
  parameter int CTRL_W  = 4,
  parameter int LATENCY = 2    // 2..6
) (
  input  logic      clk,
  input  logic      reset,     // asynchronous, active low
  alu_pipe_if.slave bus
);

  // Stage valid bits: index 0 is the operand stage, LATENCY-1 drives the output
  logic [LATENCY-1:0] valid_q;
  logic [LATENCY-1:0] load;

  // Stage 1 operand bundle
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [CTRL_W-1:0] op_q;
  logic              cin_q;

  // Result stages 2..LATENCY
  logic [WIDTH-1:0]  res_q [1:LATENCY-1];
  alu_flags_t        flg_q [1:LATENCY-1];

  logic [WIDTH-1:0]  alu_res;
  alu_flags_t        alu_flg;

  alu_core #(
    .WIDTH  (WIDTH),
    .CTRL_W (CTRL_W)
  ) u_alu_core (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .cin    (cin_q),
    .result (alu_res),
    .flags  (alu_flg)
  );

  // A stage may load unless it and every stage after it are full while the
  // consumer stalls; written without recursion so the ready chain stays flat
  always_comb begin
    logic tail_full;
    load      = '0;
    tail_full = 1'b1;
    for (int i = LATENCY - 1; i >= 0; i--) begin
      tail_full = tail_full & valid_q[i];
      load[i]   = bus.out_ready | ~tail_full;
    end
  end

  assign bus.in_ready = load[0];

  // Pipeline registers: each stage takes its predecessor whenever it loads
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      cin_q   <= 1'b0;
      for (int i = 1; i < LATENCY; i++) begin
        res_q[i] <= '0;
        flg_q[i] <= '0;
      end
    end else begin
      if (load[0]) begin
        valid_q[0] <= bus.in_valid;
        if (bus.in_valid) begin
          a_q   <= bus.A_in;
          b_q   <= bus.B_in;
          op_q  <= bus.Alu_Cntrl_in;
          cin_q <= bus.Cin_in;
        end
      end
      if (load[1]) begin
        valid_q[1] <= valid_q[0];
        if (valid_q[0]) begin
          res_q[1] <= alu_res;
          flg_q[1] <= alu_flg;
        end
      end
      for (int i = 2; i < LATENCY; i++) begin
        if (load[i]) begin
          valid_q[i] <= valid_q[i-1];
          if (valid_q[i-1]) begin
            res_q[i] <= res_q[i-1];
            flg_q[i] <= flg_q[i-1];
          end
        end
      end
    end
  end

  assign bus.out_valid = valid_q[LATENCY-1];
  assign bus.OUT       = res_q[LATENCY-1];
  assign bus.Zero      = flg_q[LATENCY-1].zero;
  assign bus.oVerflow  = flg_q[LATENCY-1].ovf;
  assign bus.Negative  = flg_q[LATENCY-1].neg;
  assign bus.Carry     = flg_q[LATENCY-1].carry;

`ifdef ALU_PIPE_STICKY_OVF_EN
  logic sticky_q;
  logic release_fire;

  assign release_fire = valid_q[LATENCY-1] & bus.out_ready;

  // Accumulate overflow over released results; a same-edge set beats clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sticky_q <= 1'b0;
    end else if (release_fire && flg_q[LATENCY-1].ovf) begin
      sticky_q <= 1'b1;
    end else if (bus.sticky_clr) begin
      sticky_q <= 1'b0;
    end
  end

  assign bus.sticky_ovf = sticky_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_pipe.sv
// ============================================================================
// Module   : tb_alu_pipe
// Purpose  : Directed self-checking bench for alu_pipe at LATENCY 2 and 4.
//            Sticky overflow checks build only with ALU_PIPE_STICKY_OVF_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_pipe;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  alu_pipe_if #(.WIDTH(32), .CTRL_W(4)) bus2 ();
  alu_pipe_if #(.WIDTH(32), .CTRL_W(4)) bus4 ();

  alu_pipe #(.WIDTH(32), .CTRL_W(4), .LATENCY(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2.slave)
  );

  alu_pipe #(.WIDTH(32), .CTRL_W(4), .LATENCY(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Issue one op on the LATENCY=2 pipe, wait (bounded) for its result,
  // capture it, then let it release; optionally pulse sticky_clr on that edge
  task automatic run2(input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] op, input logic cin, input logic clr,
                      output logic [31:0] res, output logic [3:0] fl,
                      output bit got, output int lat);
    @(negedge clk);
    bus2.out_ready    = 1'b1;
    bus2.in_valid     = 1'b1;
    bus2.A_in         = a;
    bus2.B_in         = b;
    bus2.Alu_Cntrl_in = op;
    bus2.Cin_in       = cin;
    @(negedge clk);
    bus2.in_valid = 1'b0;
    lat = 1;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus2.out_valid) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
      lat++;
    end
    res = bus2.OUT;
    fl  = {bus2.Zero, bus2.oVerflow, bus2.Negative, bus2.Carry};
`ifdef ALU_PIPE_STICKY_OVF_EN
    bus2.sticky_clr = clr;
`endif
    @(negedge clk);
`ifdef ALU_PIPE_STICKY_OVF_EN
    bus2.sticky_clr = 1'b0;
`endif
  endtask

  task automatic test_reset();
    logic [3:0] fl;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus2.in_ready !== 1'b1) begin errors++; $display("FAIL rst2_in_ready: got %b expected 1", bus2.in_ready); end
    checks++; if (bus2.out_valid !== 1'b0) begin errors++; $display("FAIL rst2_out_valid: got %b expected 0", bus2.out_valid); end
    checks++; if (bus2.OUT !== 32'h0) begin errors++; $display("FAIL rst2_out: got %h expected 0", bus2.OUT); end
    fl = {bus2.Zero, bus2.oVerflow, bus2.Negative, bus2.Carry};
    checks++; if (fl !== 4'b0000) begin errors++; $display("FAIL rst2_flags: got %b expected 0000", fl); end
    checks++; if (bus4.in_ready !== 1'b1) begin errors++; $display("FAIL rst4_in_ready: got %b expected 1", bus4.in_ready); end
    checks++; if (bus4.out_valid !== 1'b0) begin errors++; $display("FAIL rst4_out_valid: got %b expected 0", bus4.out_valid); end
`ifdef ALU_PIPE_STICKY_OVF_EN
    checks++; if (bus2.sticky_ovf !== 1'b0) begin errors++; $display("FAIL rst_sticky: got %b expected 0", bus2.sticky_ovf); end
`endif
    reset = 1'b1;
  endtask

  task automatic test_latency_ovf();
    logic [31:0] res;
    logic [3:0]  fl;
    bit          got;
    int          lat;
    run2(32'h7FFF_FFFF, 32'h1, 4'd4, 1'b0, 1'b0, res, fl, got, lat);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL ovf_timeout: got out_valid=%b expected 1", got); end
    checks++; if (lat != 2) begin errors++; $display("FAIL ovf_latency: got %0d edges expected 2", lat); end
    checks++; if (res !== 32'h8000_0000) begin errors++; $display("FAIL ovf_out: got %h expected 80000000", res); end
    checks++; if (fl !== 4'b0110) begin errors++; $display("FAIL ovf_flags: got %b expected 0110 (Z V N C)", fl); end
  endtask

  task automatic test_ops();
    logic [31:0] ta [16];
    logic [31:0] tb [16];
    logic [3:0]  top [16];
    logic        tc [16];
    logic [31:0] tr [16];
    logic [3:0]  tf [16];
    logic [31:0] res;
    logic [3:0]  fl;
    bit          got;
    int          lat;
    ta  = '{32'hF0F0F0F0, 32'h000000F0, 32'hAAAAAAAA, 32'h0, 32'h5, 32'h0, 32'h80000000, 32'hFFFFFFFF,
            32'h1, 32'h1, 32'h80000000, 32'h80000010, 32'h5, 32'h5, 32'hFFFFFFFF, 32'h80000000};
    tb  = '{32'hFF00FF00, 32'h0000000F, 32'hAAAAAAAA, 32'h0, 32'h5, 32'h1, 32'h1, 32'h1,
            32'hFFFFFFFF, 32'h3F, 32'h4, 32'h4, 32'h1234, 32'h5, 32'h0, 32'h80000000};
    top = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd5, 4'd5, 4'd6, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd15, 4'd4, 4'd4};
    tc  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tr  = '{32'hF000F000, 32'h000000FF, 32'h0, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h1,
            32'h0, 32'h80000000, 32'h08000000, 32'hF8000001, 32'h1234, 32'h0, 32'h0, 32'h0};
    tf  = '{4'b0010, 4'b0000, 4'b1000, 4'b0010, 4'b1001, 4'b0010, 4'b0101, 4'b0000,
            4'b1000, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b1000, 4'b1001, 4'b1101};
    for (int i = 0; i < 16; i++) begin
      run2(ta[i], tb[i], top[i], tc[i], 1'b0, res, fl, got, lat);
      checks++; if (got !== 1'b1) begin errors++; $display("FAIL op%0d_timeout: got out_valid=%b expected 1", i, got); end
      checks++; if (res !== tr[i]) begin errors++; $display("FAIL op%0d_out: got %h expected %h", i, res, tr[i]); end
      checks++; if (fl !== tf[i]) begin errors++; $display("FAIL op%0d_flags: got %b expected %b (Z V N C)", i, fl, tf[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int  k;
    int  rel;
    bit  fire_in;
    bit  fire_out;
    k   = 0;
    rel = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      bus4.out_ready    = (c >= 6);
      bus4.in_valid     = (k < 10);
      bus4.A_in         = k;
      bus4.B_in         = 32'd100;
      bus4.Alu_Cntrl_in = 4'd4;
      bus4.Cin_in       = 1'b0;
      #1;
      fire_in  = bus4.in_valid && bus4.in_ready;
      fire_out = bus4.out_valid && bus4.out_ready;
      if (c == 5) begin
        checks++; if (k != 4) begin errors++; $display("FAIL b2b_fill: got %0d accepts expected 4", k); end
        checks++; if (bus4.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready: got %b expected 0", bus4.in_ready); end
        checks++; if (bus4.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_stall_valid: got %b expected 1", bus4.out_valid); end
        checks++; if (bus4.OUT !== 32'd100) begin errors++; $display("FAIL b2b_stall_out: got %h expected %h", bus4.OUT, 32'd100); end
      end
      if (c == 6) begin
        checks++; if (bus4.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_no_bubble: got %b expected 1", bus4.in_ready); end
      end
      if (fire_out) begin
        checks++; if (bus4.OUT !== 32'(100 + rel)) begin errors++; $display("FAIL b2b_order%0d: got %h expected %h", rel, bus4.OUT, 32'(100 + rel)); end
        rel++;
      end
      if (fire_in) k++;
      if (rel == 10) break;
    end
    bus4.in_valid = 1'b0;
    checks++; if (rel != 10) begin errors++; $display("FAIL b2b_released: got %0d expected 10", rel); end
    checks++; if (k != 10) begin errors++; $display("FAIL b2b_accepted: got %0d expected 10", k); end
    @(negedge clk);
    checks++; if (bus4.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained: got out_valid=%b expected 0", bus4.out_valid); end
  endtask

  task automatic test_reset_flight();
    logic [3:0] fl;
    bit         got;
    bus4.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus4.in_valid     = 1'b1;
      bus4.A_in         = 32'(i + 1);
      bus4.B_in         = 32'h1;
      bus4.Alu_Cntrl_in = 4'd4;
      bus4.Cin_in       = 1'b0;
    end
    @(negedge clk);
    bus4.in_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus4.out_valid !== 1'b1) begin errors++; $display("FAIL rf_inflight: got out_valid=%b expected 1", bus4.out_valid); end
    #2;
    reset = 1'b0;
    #1;
    fl = {bus4.Zero, bus4.oVerflow, bus4.Negative, bus4.Carry};
    checks++; if (bus4.out_valid !== 1'b0) begin errors++; $display("FAIL rf_valid: got %b expected 0", bus4.out_valid); end
    checks++; if (bus4.OUT !== 32'h0) begin errors++; $display("FAIL rf_out: got %h expected 0", bus4.OUT); end
    checks++; if (fl !== 4'b0000) begin errors++; $display("FAIL rf_flags: got %b expected 0000", fl); end
    checks++; if (bus4.in_ready !== 1'b1) begin errors++; $display("FAIL rf_in_ready: got %b expected 1", bus4.in_ready); end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    bus4.out_ready    = 1'b1;
    bus4.in_valid     = 1'b1;
    bus4.A_in         = 32'd7;
    bus4.B_in         = 32'd8;
    @(negedge clk);
    bus4.in_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus4.out_valid) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL rf_timeout: got out_valid=%b expected 1", got); end
    checks++; if (bus4.OUT !== 32'd15) begin errors++; $display("FAIL rf_first: got %h expected %h", bus4.OUT, 32'd15); end
    @(negedge clk);
    checks++; if (bus4.out_valid !== 1'b0) begin errors++; $display("FAIL rf_no_stale: got out_valid=%b expected 0", bus4.out_valid); end
  endtask

`ifdef ALU_PIPE_STICKY_OVF_EN
  task automatic test_sticky();
    logic [31:0] res;
    logic [3:0]  fl;
    bit          got;
    int          lat;
    run2(32'h7FFF_FFFF, 32'h1, 4'd4, 1'b0, 1'b0, res, fl, got, lat);
    checks++; if (bus2.sticky_ovf !== 1'b1) begin errors++; $display("FAIL sticky_set: got %b expected 1", bus2.sticky_ovf); end
    run2(32'h1, 32'h1, 4'd4, 1'b0, 1'b0, res, fl, got, lat);
    checks++; if (bus2.sticky_ovf !== 1'b1) begin errors++; $display("FAIL sticky_hold: got %b expected 1", bus2.sticky_ovf); end
    run2(32'h3, 32'h1, 4'd0, 1'b0, 1'b1, res, fl, got, lat);
    checks++; if (bus2.sticky_ovf !== 1'b0) begin errors++; $display("FAIL sticky_clear: got %b expected 0", bus2.sticky_ovf); end
    run2(32'h8000_0000, 32'h8000_0000, 4'd4, 1'b0, 1'b1, res, fl, got, lat);
    checks++; if (bus2.sticky_ovf !== 1'b1) begin errors++; $display("FAIL sticky_set_wins: got %b expected 1", bus2.sticky_ovf); end
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b0;
    bus2.in_valid = 1'b0; bus2.A_in = '0; bus2.B_in = '0; bus2.Alu_Cntrl_in = '0; bus2.Cin_in = 1'b0; bus2.out_ready = 1'b1;
    bus4.in_valid = 1'b0; bus4.A_in = '0; bus4.B_in = '0; bus4.Alu_Cntrl_in = '0; bus4.Cin_in = 1'b0; bus4.out_ready = 1'b1;
`ifdef ALU_PIPE_STICKY_OVF_EN
    bus2.sticky_clr = 1'b0;
    bus4.sticky_clr = 1'b0;
`endif
    test_reset();
    test_latency_ovf();
    test_ops();
    test_back_to_back();
    test_reset_flight();
`ifdef ALU_PIPE_STICKY_OVF_EN
    test_sticky();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, pipelined successor of the registered ALU top level. Operands, opcode and carry-in enter through a valid/ready handshake, pass through a configurable number of register stages around a built-in ALU, and leave with result and flags through a second valid/ready handshake. The block sits between the instruction-issue logic and the writeback/flag logic. It sustains one operation per cycle and stalls losslessly under backpressure.

## Interface
- `WIDTH`, 32: operand and result width; must be ≥ 4.
- `CTRL_W`, 4: opcode width.
- `LATENCY`, 2: number of register stages, legal range 2..6.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operand bundle valid.
- `in_ready` out 1: block can accept a bundle this cycle.
- `A_in` in WIDTH: operand A.
- `B_in` in WIDTH: operand B.
- `Alu_Cntrl_in` in CTRL_W: opcode.
- `Cin_in` in 1: carry-in.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `OUT` out WIDTH: result.
- `Zero` out 1: zero flag.
- `oVerflow` out 1: signed-overflow flag.
- `Negative` out 1: negative flag.
- `Carry` out 1: carry flag.
- `sticky_ovf` out 1: accumulated overflow. Present only with the macro.
- `sticky_clr` in 1: clears `sticky_ovf`. Present only with the macro.

## Operation
- Accept: a bundle is taken on an edge where `in_valid && in_ready`. Release: a result is taken on an edge where `out_valid && out_ready`.
- Stage 1 registers the bundle. The ALU is combinational on the stage-1 contents. Stages 2..LATENCY carry the result and flags, each with its own valid bit.
- Advance rule: a stage loads when it is empty or its content moves forward on the same edge. `in_ready` = stage 1 empty or stage 1 advancing.
- The ready path is combinational from `out_ready` back to `in_ready`.
- Results are released in acceptance order. No bundle is dropped or duplicated.
- Opcodes:
  - 0 AND, 1 OR, 2 XOR, 3 NOR.
  - 4 ADD: {Carry,OUT} = A + B + Cin.
  - 5 SUB: {Carry,OUT} = A + ~B + 1. Carry=1 means no borrow. Cin is ignored.
  - 6 SLT: signed A<B gives 1, otherwise 0.
  - 7 SLL, 8 SRL, 9 SRA: shift amount is B[$clog2(WIDTH)-1:0].
  - 10 PASS_B.
  - All other codes: OUT=0.
- Flags:
  - Zero = (OUT==0). Negative = OUT[WIDTH-1].
  - oVerflow = signed overflow, for ADD/SUB only.
  - Carry is defined for ADD/SUB only.
  - For all other ops, Carry=0 and oVerflow=0.
- Reset:
  - All valid bits, `OUT`, `Carry`, `oVerflow`, `Negative` and `sticky_ovf` reset to 0. `Zero` resets to 0.
  - `in_ready` is 1 while `reset` is low.
  - Asserting reset mid-operation discards every in-flight bundle.

## Timing
- Latency: a bundle accepted on edge n raises `out_valid` after edge n+LATENCY-1, provided there are no stalls.
- Throughput: one bundle per cycle with `out_ready` held high.
- Stall: with `out_ready`=0, `OUT` and the flags hold stable while `out_valid`=1. The pipeline fills, then `in_ready` drops.
  - Capacity is LATENCY bundles.
- Simultaneous accept and release on a full pipeline is allowed, so there is no bubble.
- `out_valid` never drops without a release.

## Configuration
- `ALU_PIPE_STICKY_OVF_EN`: defining it adds the `sticky_ovf` and `sticky_clr` ports.
  - `sticky_ovf` sets on any release with oVerflow=1.
  - `sticky_clr` clears it on the next edge.
  - If a clear and a set fall on the same edge, the set wins.
- Without the macro, neither port exists and no sticky state is built.

## Structure
- Package `alu_pipe_pkg` holds:
  - the opcode enum `alu_op_e` (values 0..10);
  - the typedef `alu_flags_t` (packed struct of zero, ovf, neg, carry).
- Sub-module `alu_core`: the combinational ALU, parametrised by WIDTH, taking A, B, op and Cin and producing OUT and flags.
- The pipeline stages live in `alu_pipe` itself as a valid-bit register array.

## Test plan
- LATENCY=2, ADD with A=32'h7FFF_FFFF, B=1, Cin=0 → OUT=32'h8000_0000, oVerflow=1, Negative=1, Carry=0, Zero=0. `out_valid` rises after edge n+1.
- SUB with A=5, B=5 → OUT=0, Zero=1, Carry=1. SUB with A=0, B=1 → OUT=32'hFFFF_FFFF, Carry=0, Negative=1.
- LATENCY=4, stream 10 back-to-back ADDs with `out_ready`=0 for 6 cycles → `in_ready` drops after 4 accepts. All 10 results release in order with no loss.
- Drop `reset` while 3 bundles are in flight → `out_valid`=0 immediately and all outputs are 0. After release of reset, the next accepted bundle is the first seen at the output.
- SRA with A=32'h8000_0010, B=4 → OUT=32'hF800_0001. Opcode 15 → OUT=0, Zero=1.
- With `ALU_PIPE_STICKY_OVF_EN`: an overflowing ADD sets `sticky_ovf`. It stays set through later non-overflow ops. `sticky_clr` together with a new overflow on the same edge leaves it set.
